// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue; allocates tags, accepts results by tag out of order,
// and retires the head entry in program order with its exception status.
module reorder_buffer #(
  parameter int DEPTH  = 64,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int DATA_W = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              alloc_valid_i,
  input  logic [DEST_W-1:0] alloc_dest_i,
  output logic              alloc_ready_o,
  output logic [TAG_W-1:0]  alloc_tag_o,
  input  logic              wb_valid_i,
  input  logic [TAG_W-1:0]  wb_tag_i,
  input  logic [DATA_W-1:0] wb_result_i,
  input  logic              wb_exception_i,
  input  logic [3:0]        wb_exc_vector_i,
  output logic              commit_valid_o,
  input  logic              commit_ready_i,
  output logic [DEST_W-1:0] commit_dest_o,
  output logic [DATA_W-1:0] commit_result_o,
  output logic              commit_exception_o,
  output logic [3:0]        commit_exc_vector_o,
  output logic              empty_o,
  output logic              full_o
);
  localparam int PTR_W = TAG_W + 1;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
  logic [DEST_W-1:0] dest_q   [DEPTH];
  logic [DATA_W-1:0] result_q [DEPTH];
  logic              exc_q    [DEPTH];
  logic [3:0]        vec_q    [DEPTH];
  logic [TAG_W-1:0]  head_idx, tail_idx;
  logic              do_alloc, do_wb, do_commit;
  assign head_idx       = head_q[TAG_W-1:0];
  assign tail_idx       = tail_q[TAG_W-1:0];
  assign empty_o        = head_q == tail_q;
  assign full_o         = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign alloc_ready_o  = !full_o;
  assign alloc_tag_o    = tail_idx;
  assign commit_valid_o = valid_q[head_idx] & done_q[head_idx];
  assign do_alloc       = alloc_valid_i & alloc_ready_o & !flush_i;
  assign do_wb          = wb_valid_i & valid_q[wb_tag_i] & !flush_i;
  assign do_commit      = commit_valid_o & commit_ready_i & !flush_i;
  // Data outputs are masked so they read zero whenever nothing is retiring (incl. after reset).
  assign commit_dest_o       = commit_valid_o ? dest_q[head_idx]   : '0;
  assign commit_result_o     = commit_valid_o ? result_q[head_idx] : '0;
  assign commit_exception_o  = commit_valid_o ? exc_q[head_idx]    : 1'b0;
  assign commit_exc_vector_o = commit_valid_o ? vec_q[head_idx]    : '0;
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      if (do_commit) begin
        valid_d[head_idx] = 1'b0;
        head_d            = head_q + 1'b1;
      end
      if (do_wb) done_d[wb_tag_i] = 1'b1;
      if (do_alloc) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        tail_d            = tail_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_alloc) dest_q[tail_idx] <= alloc_dest_i;
    if (do_wb) begin
      result_q[wb_tag_i] <= wb_result_i;
      exc_q[wb_tag_i]    <= wb_exception_i;
      vec_q[wb_tag_i]    <= wb_exc_vector_i;
    end
  end
  a_no_double_wb: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(wb_valid_i && !flush_i && valid_q[wb_tag_i] && done_q[wb_tag_i]));
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic checked every cycle
// against a queue-based model of the retirement order.
module tb_reorder_buffer;
  localparam int DEPTH = 64;
  logic        clk_i = 0, rst_n_i = 0, flush_i = 0;
  logic        alloc_valid_i = 0, alloc_ready_o;
  logic [4:0]  alloc_dest_i = 0;
  logic [5:0]  alloc_tag_o;
  logic        wb_valid_i = 0, wb_exception_i = 0;
  logic [5:0]  wb_tag_i = 0;
  logic [31:0] wb_result_i = 0;
  logic [3:0]  wb_exc_vector_i = 0;
  logic        commit_valid_o, commit_ready_i = 0, commit_exception_o;
  logic [4:0]  commit_dest_o;
  logic [31:0] commit_result_o;
  logic [3:0]  commit_exc_vector_o;
  logic        empty_o, full_o;
  int tests = 0, fails = 0;

  reorder_buffer dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .alloc_valid_i(alloc_valid_i), .alloc_dest_i(alloc_dest_i),
    .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
    .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_result_i(wb_result_i),
    .wb_exception_i(wb_exception_i), .wb_exc_vector_i(wb_exc_vector_i),
    .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
    .commit_dest_o(commit_dest_o), .commit_result_o(commit_result_o),
    .commit_exception_o(commit_exception_o), .commit_exc_vector_o(commit_exc_vector_o),
    .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    bit          done;
    logic [31:0] res;
    bit          exc;
    logic [3:0]  vec;
  } ent_t;
  ent_t mq[$];
  int   next_tag = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_q(input int t);
    if (mq.size() == 0) return 0;
    return ((t - mq[0].tag + DEPTH) % DEPTH) < mq.size();
  endfunction

  // Model: program-order queue; the head is the next instruction to retire.
  bit   m_cv, m_ca;
  ent_t m_e;
  always @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      mq.delete();
      next_tag = 0;
    end else begin
      m_cv = mq.size() > 0 && mq[0].done;
      m_ca = mq.size() < DEPTH;
      if (wb_valid_i)
        foreach (mq[i])
          if (mq[i].tag == int'(wb_tag_i)) begin
            m_e = mq[i];
            m_e.done = 1; m_e.res = wb_result_i; m_e.exc = wb_exception_i; m_e.vec = wb_exc_vector_i;
            mq[i] = m_e;
          end
      if (m_cv && commit_ready_i) void'(mq.pop_front());
      if (alloc_valid_i && m_ca) begin
        m_e = '{tag: next_tag, dest: alloc_dest_i, done: 0, res: 0, exc: 0, vec: 0};
        mq.push_back(m_e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
  end

  bit c_cv;
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      check("rst_empty", 64'(empty_o), 1);
      check("rst_full", 64'(full_o), 0);
      check("rst_ready", 64'(alloc_ready_o), 1);
      check("rst_tag", 64'(alloc_tag_o), 0);
      check("rst_cvalid", 64'(commit_valid_o), 0);
      check("rst_cresult", 64'(commit_result_o), 0);
    end else begin
      c_cv = mq.size() > 0 && mq[0].done;
      check("m_empty", 64'(empty_o), 64'(mq.size() == 0));
      check("m_full", 64'(full_o), 64'(mq.size() == DEPTH));
      check("m_ready", 64'(alloc_ready_o), 64'(mq.size() != DEPTH));
      check("m_tag", 64'(alloc_tag_o), 64'(next_tag));
      check("m_cvalid", 64'(commit_valid_o), 64'(c_cv));
      check("m_cdest", 64'(commit_dest_o), c_cv ? 64'(mq[0].dest) : 0);
      check("m_cresult", 64'(commit_result_o), c_cv ? 64'(mq[0].res) : 0);
      check("m_cexc", 64'(commit_exception_o), c_cv ? 64'(mq[0].exc) : 0);
      check("m_cvec", 64'(commit_exc_vector_o), c_cv ? 64'(mq[0].vec) : 0);
    end
  end

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    flush_i = 0; alloc_valid_i = 0; wb_valid_i = 0; wb_exception_i = 0; wb_exc_vector_i = 0;
  endtask

  task automatic alloc(input logic [4:0] d);
    alloc_valid_i = 1; alloc_dest_i = d; cyc(); alloc_valid_i = 0;
  endtask

  task automatic wb(input int t, input logic [31:0] r, input bit e, input logic [3:0] v);
    wb_valid_i = 1; wb_tag_i = 6'(t); wb_result_i = r; wb_exception_i = e; wb_exc_vector_i = v;
    cyc(); wb_valid_i = 0; wb_exception_i = 0; wb_exc_vector_i = 0;
  endtask

  task automatic do_flush();
    flush_i = 1; cyc(); flush_i = 0;
  endtask

  task automatic drive_rand();
    int cand[$];
    int t;
    idle();
    flush_i        = ($urandom_range(0, 63) == 0);
    commit_ready_i = ($urandom_range(0, 9) < 7);
    alloc_valid_i  = ($urandom_range(0, 9) < 6);
    alloc_dest_i   = 5'($urandom);
    foreach (mq[i]) if (!mq[i].done) cand.push_back(mq[i].tag);
    if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
      wb_valid_i = 1;
      wb_tag_i   = 6'(cand[$urandom_range(0, cand.size() - 1)]);
    end else if (mq.size() < DEPTH && $urandom_range(0, 3) == 0) begin
      t = $urandom_range(0, DEPTH - 1);
      for (int k = 0; k < 8 && in_q(t); k++) t = (t + 1) % DEPTH;
      wb_valid_i = !in_q(t);
      wb_tag_i   = 6'(t);
    end
    wb_result_i     = $urandom;
    wb_exception_i  = $urandom_range(0, 7) == 0;
    wb_exc_vector_i = wb_exception_i ? 4'($urandom_range(0, 1)) : 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(); cyc();
    rst_n_i = 1;
    #1;
    check("t1_empty", 64'(empty_o), 1);
    check("t1_ready", 64'(alloc_ready_o), 1);
    check("t1_tag", 64'(alloc_tag_o), 0);
    check("t1_cvalid", 64'(commit_valid_o), 0);
    check("t1_full", 64'(full_o), 0);

    alloc(5); alloc(6); alloc(7);
    wb(2, 32'h77, 0, 0); #1;
    check("t2_no_early_commit", 64'(commit_valid_o), 0);
    wb(0, 32'hAA, 0, 0); #1;
    check("t2_cvalid", 64'(commit_valid_o), 1);
    check("t2_dest0", 64'(commit_dest_o), 5);
    check("t2_res0", 64'(commit_result_o), 32'hAA);
    commit_ready_i = 1;
    wb(1, 32'h66, 0, 0); #1;
    check("t2_dest1", 64'(commit_dest_o), 6);
    check("t2_res1", 64'(commit_result_o), 32'h66);
    cyc(); #1;
    check("t2_dest2", 64'(commit_dest_o), 7);
    check("t2_res2", 64'(commit_result_o), 32'h77);
    cyc(); #1;
    check("t2_empty", 64'(empty_o), 1);
    commit_ready_i = 0;

    do_flush();
    for (int i = 0; i < DEPTH; i++) alloc(5'(i));
    #1;
    check("t3_full", 64'(full_o), 1);
    check("t3_ready", 64'(alloc_ready_o), 0);
    for (int i = 0; i < DEPTH; i++) wb(i, 32'(i * 3 + 1), 0, 0);
    commit_ready_i = 1; alloc_valid_i = 1; alloc_dest_i = 5'd31;
    cyc();
    commit_ready_i = 0; alloc_valid_i = 0; #1;
    check("t3_ready_after", 64'(alloc_ready_o), 1);
    check("t3_wrap_tag", 64'(alloc_tag_o), 0);
    check("t3_head_adv", 64'(commit_result_o), 4);
    commit_ready_i = 1;
    for (int i = 0; i < DEPTH - 1; i++) cyc();
    commit_ready_i = 0; #1;
    check("t3_drained", 64'(empty_o), 1);

    do_flush();
    alloc(3); alloc(4);
    wb(1, 32'h22, 1, 4'b0001);
    wb(0, 32'h11, 1, 4'b0000); #1;
    check("t4_exc", 64'(commit_exception_o), 1);
    check("t4_vec", 64'(commit_exc_vector_o), 0);
    check("t4_dest", 64'(commit_dest_o), 3);
    commit_ready_i = 1; cyc(); commit_ready_i = 0; #1;
    check("t4_vec1", 64'(commit_exc_vector_o), 1);
    do_flush(); #1;
    check("t4_flush_empty", 64'(empty_o), 1);
    check("t4_flush_tag", 64'(alloc_tag_o), 0);

    alloc(8);
    wb(0, 32'h1234, 0, 0); #1;
    check("t5_cvalid", 64'(commit_valid_o), 1);
    flush_i = 1; alloc_valid_i = 1; alloc_dest_i = 9; commit_ready_i = 1;
    cyc();
    idle(); commit_ready_i = 0; #1;
    check("t5_empty", 64'(empty_o), 1);
    check("t5_tag", 64'(alloc_tag_o), 0);
    check("t5_cvalid", 64'(commit_valid_o), 0);

    alloc(9); alloc(10);
    wb(0, 32'h5A5A, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      check("t6_hold_valid", 64'(commit_valid_o), 1);
      check("t6_hold_res", 64'(commit_result_o), 32'h5A5A);
      check("t6_hold_dest", 64'(commit_dest_o), 9);
    end
    rst_n_i = 0; #1;
    check("t6_rst_empty", 64'(empty_o), 1);
    check("t6_rst_cvalid", 64'(commit_valid_o), 0);
    check("t6_rst_res", 64'(commit_result_o), 0);
    check("t6_rst_tag", 64'(alloc_tag_o), 0);
    cyc(); cyc();
    rst_n_i = 1;

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        idle(); rst_n_i = 0; cyc(); cyc(); rst_n_i = 1;
      end
      drive_rand();
      cyc();
    end
    idle(); commit_ready_i = 0;
    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
